add_err_monitor: RTL and testbench
==================================

Name: add_err_monitor

Overview:
- Sequential error-statistics stage directly downstream of a 16-bit unsigned adder circuit (exact or approximate variant).
- Consumes the operands and the adder's 17-bit result through a valid/ready handshake and recomputes the exact sum internally.
- Accumulates error statistics over a fixed window of samples: error count (for EP), worst-case error (WCE) and sum of absolute errors (for MAE).
- Used for on-silicon/FPGA characterisation of adder variants.

Parameters:
W, 16, operand width; the adder result is W+1 bits.
SAMPLES, 1024, number of samples per measurement window; must be ≥ 1.
CNT_W, 11, counter width; must satisfy 2^CNT_W > SAMPLES.
ACC_W, W+1+CNT_W, width of the absolute-error accumulator; sized so it never overflows.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins a measurement window
in_valid  input  1  sample valid
in_ready  output  1  monitor accepts a sample this cycle
a  input  W  operand A fed to the adder
b  input  W  operand B fed to the adder
o_dut  input  W+1  adder result for (a,b)
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE; the statistics are final
err_cnt  output  CNT_W  number of samples with o_dut != a+b
wce  output  W+1  maximum |a+b - o_dut| seen in the window
sae  output  ACC_W  sum of |a+b - o_dut| over the window

Behaviour:
- Reset (asynchronous, rst_n low): state = IDLE; accept counter, pipeline valids, err_cnt, wce and sae all 0; in_ready = busy = done = 0. Reset mid-window discards all progress.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Entering RUN clears counters and accumulators in the same cycle.
  - RUN -> DRAIN in the cycle after the accept counter reaches SAMPLES.
  - DRAIN -> DONE once both pipeline stages are empty.
  - DONE -> RUN on start, with a fresh clear. Otherwise DONE holds its values indefinitely.
  - start is ignored in RUN and DRAIN.
- Handshake:
  - in_ready = (state == RUN) && (accept_cnt < SAMPLES).
  - A transfer occurs when in_valid && in_ready. in_valid without in_ready is neither counted nor consumed.
  - No combinational path from in_valid to in_ready.
- Pipeline:
  - Stage 1 registers a, b and o_dut, computes exact = a + b at width W+1, and registers exact and o_dut.
  - Stage 2 computes diff = |exact - o_dut| at width W+1 (unsigned magnitude, larger minus smaller) and updates the statistics:
    - err_cnt += (diff != 0)
    - wce = max(wce, diff)
    - sae += diff, zero-extended to ACC_W
  - Latency: a sample accepted in cycle t affects the outputs at the edge ending cycle t+2.
  - Throughput: 1 sample per cycle.
- DRAIN lasts ≤ 2 cycles after the last accept. done asserts the cycle after the last stage-2 update.
- Outputs err_cnt, wce and sae are registered and update live during RUN; they are meaningful only while done = 1.
- Width rules:
  - No truncation anywhere.
  - err_cnt ≤ SAMPLES.
  - sae ≤ SAMPLES·(2^(W+1)-1), which fits ACC_W.
  - An elaboration-time check rejects SAMPLES = 0 and any CNT_W too small for SAMPLES.

Decomposition:
- Shared package add_mon_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE)
  - the W/SAMPLES defaults
  - a function clog2-based width helper.
- One sub-module, add_err_stage: the combinational exact-sum / absolute-difference datapath, so it can be reused for other adder widths.
- FSM, counters and accumulators stay in the top.

Test Plan:
- Exact adder model, SAMPLES=4, random a/b, in_valid held high -> done after 4 accepts + drain; err_cnt=0, wce=0, sae=0.
- SAMPLES=4, o_dut = a+b+1 for every sample -> err_cnt=4, wce=1, sae=4.
- SAMPLES=2, first sample a=0xFFFF, b=0xFFFF, o_dut=0x00000 (err 0x1FFFE), second sample error 3 -> wce=0x1FFFE, sae=0x20001, err_cnt=2.
- Backpressure and gaps: in_valid toggled 1,0,0,1,1,0,1 with SAMPLES=4 -> exactly 4 samples accepted; in_ready drops after the 4th; later valid samples are ignored and the statistics match a software model.
- start pulses during RUN, and rst_n asserted mid-window after 2 accepts -> start has no effect; after reset all outputs are 0 in IDLE and a new start measures a clean window.
- Back-to-back windows: start in DONE -> statistics clear in the RUN entry cycle; the second window's results are independent of the first.

Source files
------------

// File: rtl/add_mon_pkg.sv
// Shared types and defaults for the adder error monitor.
// Holds the window FSM encoding and the counter-width helper.
package add_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

    localparam int DEF_W       = 16;
    localparam int DEF_SAMPLES = 1024;

    // Smallest counter width that can still represent the value `samples`.
    function automatic int cnt_width(input int samples);
        return $clog2(samples + 1);
    endfunction

endpackage

// File: rtl/add_err_stage.sv
// Exact-sum and absolute-difference datapath; purely combinational, 0 cycles.
// No handshake: the caller qualifies inputs and outputs with its own valids.
module add_err_stage #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum,
    input  logic [W:0]   lhs,
    input  logic [W:0]   rhs,
    output logic [W:0]   abs_diff
);

    assign sum      = {1'b0, a} + {1'b0, b};
    assign abs_diff = (lhs >= rhs) ? (lhs - rhs) : (rhs - lhs);

endmodule

// File: rtl/add_err_monitor.sv
// Error statistics (count, worst case, abs-error sum) for an adder over a window; sample -> stats in 2 cycles.
// in_ready is high only in RUN until SAMPLES accepts; unaccepted valid samples are left untouched.
module add_err_monitor
    import add_mon_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int SAMPLES = DEF_SAMPLES,
    parameter int CNT_W   = 11,
    parameter int ACC_W   = W + 1 + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W:0]       o_dut,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output logic [W:0]       wce,
    output logic [ACC_W-1:0] sae
);

    if (SAMPLES < 1) begin : g_bad_samples
        $error("add_err_monitor: SAMPLES must be at least 1");
    end
    if (CNT_W < cnt_width(SAMPLES)) begin : g_bad_cnt_w
        $error("add_err_monitor: CNT_W too small to hold SAMPLES");
    end

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             s1_vld_q, s1_vld_d;
    logic [W-1:0]     s1_a_q, s1_a_d;
    logic [W-1:0]     s1_b_q, s1_b_d;
    logic [W:0]       s1_o_q, s1_o_d;
    logic             s2_vld_q, s2_vld_d;
    logic [W:0]       s2_exact_q, s2_exact_d;
    logic [W:0]       s2_o_q, s2_o_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [W:0]       wce_q, wce_d;
    logic [ACC_W-1:0] sae_q, sae_d;

    logic       accept;
    logic       clear;
    logic [W:0] exact_w;
    logic [W:0] diff_w;

    add_err_stage #(.W(W)) u_stage (
        .a        (s1_a_q),
        .b        (s1_b_q),
        .sum      (exact_w),
        .lhs      (s2_exact_q),
        .rhs      (s2_o_q),
        .abs_diff (diff_w)
    );

    // in_ready depends on registered state only, never on in_valid.
    assign in_ready = (state_q == ST_RUN) && (acc_cnt_q < CNT_W'(SAMPLES));
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign err_cnt  = err_cnt_q;
    assign wce      = wce_q;
    assign sae      = sae_q;

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (acc_cnt_q == CNT_W'(SAMPLES)) state_d = ST_DRAIN;
            end
            // Stage 2 retires its last sample on this same edge.
            ST_DRAIN: begin
                if (!s1_vld_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_cnt_d  = accept ? acc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : acc_cnt_q;
        s1_vld_d   = accept;
        s1_a_d     = accept ? a     : s1_a_q;
        s1_b_d     = accept ? b     : s1_b_q;
        s1_o_d     = accept ? o_dut : s1_o_q;
        s2_vld_d   = s1_vld_q;
        s2_exact_d = s1_vld_q ? exact_w : s2_exact_q;
        s2_o_d     = s1_vld_q ? s1_o_q  : s2_o_q;
        err_cnt_d  = err_cnt_q;
        wce_d      = wce_q;
        sae_d      = sae_q;
        if (s2_vld_q) begin
            err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, |diff_w};
            wce_d     = (diff_w > wce_q) ? diff_w : wce_q;
            sae_d     = sae_q + {{(ACC_W-W-1){1'b0}}, diff_w};
        end
        if (clear) begin
            acc_cnt_d = '0;
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            err_cnt_d = '0;
            wce_d     = '0;
            sae_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_cnt_q  <= '0;
            s1_vld_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_o_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_exact_q <= '0;
            s2_o_q     <= '0;
            err_cnt_q  <= '0;
            wce_q      <= '0;
            sae_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_cnt_q  <= acc_cnt_d;
            s1_vld_q   <= s1_vld_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_o_q     <= s1_o_d;
            s2_vld_q   <= s2_vld_d;
            s2_exact_q <= s2_exact_d;
            s2_o_q     <= s2_o_d;
            err_cnt_q  <= err_cnt_d;
            wce_q      <= wce_d;
            sae_q      <= sae_d;
        end
    end

endmodule

// File: tb/tb_add_err_monitor.sv
// Directed bench for add_err_monitor: a 4-sample instance and a 2-sample instance
// share operand buses but have their own start/valid controls.
module tb_add_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, vld_a = 1'b0;
    logic        start_b = 1'b0, vld_b = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [16:0] o_dut = '0;

    logic        rdy_a, busy_a, done_a;
    logic [2:0]  err_a;
    logic [16:0] wce_a;
    logic [19:0] sae_a;

    logic        rdy_b, busy_b, done_b;
    logic [1:0]  err_b;
    logic [16:0] wce_b;
    logic [18:0] sae_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    add_err_monitor #(.W(16), .SAMPLES(4), .CNT_W(3), .ACC_W(20)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(vld_a), .in_ready(rdy_a),
        .a(a), .b(b), .o_dut(o_dut), .busy(busy_a), .done(done_a),
        .err_cnt(err_a), .wce(wce_a), .sae(sae_a)
    );

    add_err_monitor #(.W(16), .SAMPLES(2), .CNT_W(2), .ACC_W(19)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(vld_b), .in_ready(rdy_b),
        .a(a), .b(b), .o_dut(o_dut), .busy(busy_b), .done(done_b),
        .err_cnt(err_b), .wce(wce_b), .sae(sae_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit to_b);
        if (to_b) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Drive one cycle of stimulus; o_dut = a + b + off (mod 2^17).
    task automatic step(input bit to_b, input bit v, input logic [15:0] x, input logic [15:0] y,
                        input logic [16:0] off);
        a     = x;
        b     = y;
        o_dut = {1'b0, x} + {1'b0, y} + off;
        if (to_b) vld_b = v; else vld_a = v;
        tick();
    endtask

    task automatic wait_done(input bit to_b, input string tag);
        int n = 0;
        vld_a = 1'b0;
        vld_b = 1'b0;
        while (!(to_b ? done_b : done_a) && n < 12) begin
            tick();
            n++;
        end
        chk(tag, 32'(to_b ? done_b : done_a), 32'd1);
    endtask

    task automatic chk_stats_a(input string tag, input int e, input int w, input int s);
        chk({tag, "_err"}, 32'(err_a), 32'(e));
        chk({tag, "_wce"}, 32'(wce_a), 32'(w));
        chk({tag, "_sae"}, 32'(sae_a), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] rx, ry;

        // Reset state
        #3;
        chk("rst_rdy_a", 32'(rdy_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk_stats_a("rst_a", 0, 0, 0);
        chk("rst_done_b", 32'(done_b), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_rdy_a", 32'(rdy_a), 32'd0);

        // T1: exact adder, random operands, valid held high
        pulse_start(1'b0);
        chk("t1_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rdy", 32'(rdy_a), 32'd1);
            rx = 16'($urandom);
            ry = 16'($urandom);
            step(1'b0, 1'b1, rx, ry, 17'd0);
        end
        chk("t1_rdy_full", 32'(rdy_a), 32'd0);
        wait_done(1'b0, "t1_done");
        chk("t1_busy_done", 32'(busy_a), 32'd0);
        chk_stats_a("t1", 0, 0, 0);
        tick(); tick(); tick();
        chk("t1_done_hold", 32'(done_a), 32'd1);

        // T2: off-by-one adder on every sample
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            step(1'b0, 1'b1, rx, ry, 17'd1);
        end
        wait_done(1'b0, "t2_done");
        chk_stats_a("t2", 4, 1, 4);

        // T3: 2-sample instance, maximum-magnitude error then error 3
        pulse_start(1'b1);
        step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 17'h00002);
        step(1'b1, 1'b1, 16'h0001, 16'h0002, 17'h1FFFD);
        chk("t3_rdy_full", 32'(rdy_b), 32'd0);
        wait_done(1'b1, "t3_done");
        chk("t3_err", 32'(err_b), 32'd2);
        chk("t3_wce", 32'(wce_b), 32'h1FFFE);
        chk("t3_sae", 32'(sae_b), 32'h20001);

        // T4: gaps in valid (1,0,0,1,1,0,1); later samples must be ignored
        pulse_start(1'b0);
        step(1'b0, 1'b1, 16'h1234, 16'h4321, 17'd0);
        step(1'b0, 1'b0, 16'h1234, 16'h4321, 17'h100);
        step(1'b0, 1'b0, 16'h1234, 16'h4321, 17'h100);
        step(1'b0, 1'b1, 16'h1234, 16'h4321, 17'd5);
        step(1'b0, 1'b1, 16'h1234, 16'h4321, 17'h1FFFE);
        step(1'b0, 1'b0, 16'h1234, 16'h4321, 17'h100);
        step(1'b0, 1'b1, 16'h1234, 16'h4321, 17'd7);
        for (int i = 0; i < 3; i++) begin
            chk("t4_rdy_low", 32'(rdy_a), 32'd0);
            step(1'b0, 1'b1, 16'h1234, 16'h4321, 17'h1000);
        end
        wait_done(1'b0, "t4_done");
        chk_stats_a("t4", 3, 7, 14);

        // T5: start during RUN is ignored; reset mid-window discards everything
        pulse_start(1'b0);
        step(1'b0, 1'b1, 16'h1234, 16'h4321, 17'd6);
        step(1'b0, 1'b1, 16'h1234, 16'h4321, 17'd6);
        vld_a = 1'b0;
        pulse_start(1'b0);
        tick(); tick();
        chk("t5_busy", 32'(busy_a), 32'd1);
        chk("t5_rdy", 32'(rdy_a), 32'd1);
        chk_stats_a("t5_live", 2, 6, 12);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy_a), 32'd0);
        chk("t5_rst_rdy", 32'(rdy_a), 32'd0);
        chk("t5_rst_done", 32'(done_a), 32'd0);
        chk_stats_a("t5_rst", 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(1'b0);
        step(1'b0, 1'b1, 16'h0100, 16'h0200, 17'd0);
        step(1'b0, 1'b1, 16'h0100, 16'h0200, 17'd0);
        step(1'b0, 1'b1, 16'h0100, 16'h0200, 17'd0);
        step(1'b0, 1'b1, 16'h0100, 16'h0200, 17'd9);
        wait_done(1'b0, "t5_done");
        chk_stats_a("t5_clean", 1, 9, 9);

        // T6: back-to-back window, clear on RUN entry
        pulse_start(1'b0);
        chk("t6_busy", 32'(busy_a), 32'd1);
        chk("t6_done", 32'(done_a), 32'd0);
        chk_stats_a("t6_clear", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 16'h0010, 16'h0020, 17'h1FFFE);
        end
        wait_done(1'b0, "t6_done2");
        chk_stats_a("t6", 4, 2, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
